// File: rtl/uart_apb_sequencer.sv
// uart_apb_sequencer: APB master that programs the UART baud registers, then services RX reads and round-robin TX writes
//
// Ports:
//    PCLK, PRESET           clock, asynchronous active-high reset
//    PSEL, PENABLE, PADDR,  APB master request (registered)
//    PWRITE, PWDATA
//    PRDATA, PREADY         APB slave response
//    TXRDY, RXRDY           UART transmit space / receive byte available
//    req, req_data0/1       level TX requests and their bytes, held until ack
//    ack                    one-cycle pulse on the served requester's bit
//    rx_data, rx_valid      last byte read from the RX register, update strobe
//    init_done              sticky once both configuration writes complete
//    err                    one-cycle pulse when a transfer is abandoned on PREADY timeout
module uart_apb_sequencer #(
   parameter logic [7:0] BAUD_LO  = 8'h0D,
   parameter logic [7:0] BAUD_CFG = 8'h00,
   parameter int         TIMEOUT  = 16
) (
   input  logic       PCLK,
   input  logic       PRESET,
   output logic       PSEL,
   output logic       PENABLE,
   output logic [1:0] PADDR,
   output logic       PWRITE,
   output logic [7:0] PWDATA,
   input  logic [7:0] PRDATA,
   input  logic       PREADY,
   input  logic       TXRDY,
   input  logic       RXRDY,
   input  logic [1:0] req,
   input  logic [7:0] req_data0,
   input  logic [7:0] req_data1,
   output logic [1:0] ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       init_done,
   output logic       err
);
   typedef enum logic [3:0] {
      INIT0_SETUP, INIT0_ACCESS, INIT1_SETUP, INIT1_ACCESS, GAP, IDLE,
      RX_SETUP, RX_ACCESS, TX_SETUP, TX_ACCESS
   } state_t;
   state_t     state, after_gap;
   logic       ptr, grant, in_access, expire, pick;
   logic [7:0] cnt, cnt_nxt;
   assign in_access = state inside {INIT0_ACCESS, INIT1_ACCESS, RX_ACCESS, TX_ACCESS};
   assign cnt_nxt   = cnt + 8'd1;
   assign expire    = in_access && !PREADY && cnt_nxt == 8'(TIMEOUT);
   // both requesting: the pointer decides; otherwise the single active bit
   assign pick      = (req == 2'b11) ? ptr : req[1];
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state     <= INIT0_SETUP;
         after_gap <= IDLE;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PADDR     <= 2'b00;
         PWRITE    <= 1'b0;
         PWDATA    <= 8'h00;
         ack       <= 2'b00;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         init_done <= 1'b0;
         err       <= 1'b0;
         ptr       <= 1'b0;
         grant     <= 1'b0;
         cnt       <= 8'h00;
      end else begin
         ack      <= 2'b00;
         rx_valid <= 1'b0;
         err      <= 1'b0;
         case (state)
            INIT0_SETUP, INIT1_SETUP, RX_SETUP, TX_SETUP: begin
               // PSEL is low here only in the first cycle after reset: launch the first init write
               if (!PSEL) begin
                  PSEL   <= 1'b1;
                  PWRITE <= 1'b1;
                  PADDR  <= 2'b00;
                  PWDATA <= BAUD_LO;
                  cnt    <= 8'h00;
               end else begin
                  PENABLE <= 1'b1;
                  state   <= state == INIT0_SETUP ? INIT0_ACCESS :
                             state == INIT1_SETUP ? INIT1_ACCESS :
                             state == RX_SETUP    ? RX_ACCESS    : TX_ACCESS;
               end
            end
            INIT0_ACCESS, INIT1_ACCESS, RX_ACCESS, TX_ACCESS: begin
               if (PREADY || expire) begin
                  PSEL    <= 1'b0;
                  PENABLE <= 1'b0;
                  state   <= GAP;
               end else
                  cnt <= cnt_nxt;
               if (expire) begin
                  // abandoned: init steps retry themselves, TX/RX leave the pointer alone
                  err       <= 1'b1;
                  after_gap <= state == INIT0_ACCESS ? INIT0_SETUP :
                               state == INIT1_ACCESS ? INIT1_SETUP : IDLE;
               end else if (PREADY) begin
                  after_gap <= state == INIT0_ACCESS ? INIT1_SETUP : IDLE;
                  if (state == INIT1_ACCESS)
                     init_done <= 1'b1;
                  if (state == RX_ACCESS) begin
                     rx_data  <= PRDATA;
                     rx_valid <= 1'b1;
                  end
                  if (state == TX_ACCESS) begin
                     ack[grant] <= 1'b1;
                     ptr        <= ~grant;
                  end
               end
            end
            GAP: begin
               state <= after_gap;
               if (after_gap != IDLE) begin
                  PSEL   <= 1'b1;
                  PWRITE <= 1'b1;
                  PADDR  <= after_gap == INIT1_SETUP ? 2'b01 : 2'b00;
                  PWDATA <= after_gap == INIT1_SETUP ? BAUD_CFG : BAUD_LO;
                  cnt    <= 8'h00;
               end
            end
            IDLE: begin
               if (RXRDY) begin
                  state  <= RX_SETUP;
                  PSEL   <= 1'b1;
                  PWRITE <= 1'b0;
                  PADDR  <= 2'b11;
                  cnt    <= 8'h00;
               end else if (TXRDY && req != 2'b00) begin
                  state  <= TX_SETUP;
                  PSEL   <= 1'b1;
                  PWRITE <= 1'b1;
                  PADDR  <= 2'b10;
                  PWDATA <= pick ? req_data1 : req_data0;
                  grant  <= pick;
                  cnt    <= 8'h00;
               end
            end
            default: begin
               state   <= IDLE;
               PSEL    <= 1'b0;
               PENABLE <= 1'b0;
            end
         endcase
      end
   end
endmodule
